mult_seq: RTL
=============

Name: mult_seq

Overview:
- Multi-cycle signed shift-add multiplier. It is the inverse-operation companion of the team's sequential divider and uses the same valid_in/valid_out style.
- Used by the FM demodulator and gain paths where a full-width combinational multiplier is too costly.
- Operates sign-magnitude: it takes operand magnitudes, accumulates one multiplier bit per cycle, and applies the sign in an epilogue.

Parameters:
- MULTIPLICAND_WIDTH, 32, width of signed multiplicand A (minimum 2).
- MULTIPLIER_WIDTH, 32, width of signed multiplier B. Also sets the iteration count (minimum 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  operands valid; accepted only when ready=1.
- ready  output  1  high in IDLE; block can accept an operation.
- multiplicand  input  MULTIPLICAND_WIDTH  signed two's-complement A.
- multiplier  input  MULTIPLIER_WIDTH  signed two's-complement B.
- product  output  MULTIPLICAND_WIDTH+MULTIPLIER_WIDTH  signed A*B; held until the next result.
- valid_out  output  1  one-cycle pulse: product is valid.

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state=IDLE, ready=1, valid_out=0, product=0.
  - Internal accumulator, magnitude and sign registers cleared.
- States: IDLE, LOOP, EPILOGUE, DONE.
- IDLE:
  - ready=1.
  - On an edge with valid_in=1, capture the operands:
    - sign = A[msb] XOR B[msb].
    - |A| and |B| as unsigned magnitudes. The most-negative value maps to 2^(W-1) with no overflow.
    - acc=0, count=0.
  - If A==0 or B==0, go to EPILOGUE (zero shortcut). Otherwise go to LOOP.
  - With valid_in=0, stay in IDLE.
- LOOP:
  - ready=0.
  - Each cycle: if magB[0]=1, acc += magA << count. Then magB >>= 1 and count++.
  - Exactly MULTIPLIER_WIDTH cycles, then go to EPILOGUE. There is no early exit on magB==0.
- EPILOGUE:
  - ready=0.
  - product register <= sign ? -acc : acc, computed in full output width.
  - Next state is DONE.
- DONE:
  - valid_out=1 for this cycle only, ready=0.
  - Next state is IDLE.
- Latency, counted in edges from the accepting edge to the first edge at which valid_out=1 is sampled:
  - MULTIPLIER_WIDTH+2 for normal operands (34 at default widths).
  - 2 for the zero shortcut.
  - Back-to-back throughput: a new op can be accepted at the edge following the valid_out cycle.
- Width rules:
  - Accumulator is MULTIPLICAND_WIDTH+MULTIPLIER_WIDTH bits unsigned; the product always fits and there is no overflow output.
  - The only maximum-magnitude positive result, (-2^(MA-1))*(-2^(MB-1)) = 2^(MA+MB-2), is representable.
- Boundary conditions:
  - valid_in while ready=0: ignored. Operands are not re-sampled; the in-flight op is unaffected and nothing is queued.
  - Operand inputs change after acceptance: no effect.
  - product holds its last value through IDLE and the next op's LOOP. It changes only in EPILOGUE.
  - reset asserted in any state, including mid-LOOP:
    - Next cycle: IDLE, product=0, valid_out=0, ready=1.
    - The in-flight result is discarded; valid_out never pulses for it.
  - reset and valid_in on the same edge: reset wins and the op is not accepted.
  - Multiplier = -1 or multiplicand = -1: no special path; full LOOP latency.

Test Plan:
1. A=3, B=5 accepted at edge 0 -> ready low from edge 1. valid_out=1 sampled at edge 34 only, product=15. ready=1 again after edge 34.
2. A=-7, B=6 -> product=-42 (0xFFFF_FFFF_FFFF_FFD6). Then A=-2^31, B=-2^31 accepted at the first ready edge -> product=0x4000_0000_0000_0000; A=-2^31, B=1 -> 0xFFFF_FFFF_8000_0000.
3. A=0, B=0x1234 -> valid_out at edge 2, product=0. Then A=-9, B=0 -> product=0, latency 2.
4. A=100, B=-3 accepted. Pulse valid_in with A=1, B=1 at edges 5..20 -> ignored, single valid_out at edge 34 with product=-300. No second pulse.
5. Start A=12345, B=678. Assert reset at edge 10 -> from edge 11 ready=1, product=0, and no valid_out ever appears. Then A=2, B=2 -> product=4 at latency 34.
6. Random signed pairs (≥1000, including ±max and most-negative values) checked against a reference model -> all products exact, every latency equals 34 or 2.

Source files
------------

// File: rtl/mult_seq.sv
// -----------------------------------------------------------------------------
// mult_seq
//
// Multi-cycle signed shift-add multiplier for the FM demodulator and gain paths,
// where a full-width combinational multiplier is too costly.
//
// The operands are converted to unsigned magnitudes when they are accepted.
// LOOP then consumes one multiplier bit per cycle into an unsigned accumulator.
// EPILOGUE applies the sign and loads the product register.
// Normal operands take MULTIPLIER_WIDTH+2 edges from acceptance to valid_out.
// If either operand is zero the op skips LOOP and takes 2 edges.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   valid_in     operands valid; taken only while ready=1
//   ready        high in IDLE; an operation can be accepted
//   multiplicand signed A, MULTIPLICAND_WIDTH bits (minimum 2)
//   multiplier   signed B, MULTIPLIER_WIDTH bits (minimum 2); also the loop count
//   product      signed A*B, full width; holds until the next result
//   valid_out    one-cycle pulse marking a new product
// -----------------------------------------------------------------------------
module mult_seq #(
   parameter int MULTIPLICAND_WIDTH = 32,
   parameter int MULTIPLIER_WIDTH   = 32
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic                                         valid_in,
   output logic                                         ready,
   input  logic [MULTIPLICAND_WIDTH-1:0]                multiplicand,
   input  logic [MULTIPLIER_WIDTH-1:0]                  multiplier,
   output logic [MULTIPLICAND_WIDTH+MULTIPLIER_WIDTH-1:0] product,
   output logic                                         valid_out
);

   localparam int MA = MULTIPLICAND_WIDTH;
   localparam int MB = MULTIPLIER_WIDTH;
   localparam int PW = MA + MB;
   // The counter only needs to reach MB-1, which is the last LOOP iteration.
   localparam int CW = $clog2(MB);
   localparam logic [CW-1:0] LAST_COUNT = CW'(MB - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOOP     = 2'd1,
      EPILOGUE = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t          state_reg;
   logic [MA-1:0]   mag_a_reg;
   logic [MB-1:0]   mag_b_reg;
   logic [PW-1:0]   acc_reg;
   logic [CW-1:0]   count_reg;
   logic            sign_reg;
   logic            ready_reg;
   logic            valid_out_reg;
   logic [PW-1:0]   product_reg;

   // Negating an operand as an unsigned W-bit value maps the most-negative
   // input to 2^(W-1). That value still fits, so no extra bit is needed.
   logic [MA-1:0]   mag_a_in;
   logic [MB-1:0]   mag_b_in;
   logic            zero_in;
   logic [PW-1:0]   addend;

   assign mag_a_in = multiplicand[MA-1] ? (MA'(0) - multiplicand) : multiplicand;
   assign mag_b_in = multiplier[MB-1]   ? (MB'(0) - multiplier)   : multiplier;
   assign zero_in  = (multiplicand == '0) || (multiplier == '0);

   // The multiplicand magnitude is zero-extended to full product width, so
   // shifting it by up to MB-1 bits never overflows.
   assign addend   = {{MB{1'b0}}, mag_a_reg};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         mag_a_reg     <= '0;
         mag_b_reg     <= '0;
         acc_reg       <= '0;
         count_reg     <= '0;
         sign_reg      <= 1'b0;
         ready_reg     <= 1'b1;
         valid_out_reg <= 1'b0;
         product_reg   <= '0;
      end else begin
         valid_out_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (valid_in) begin
                  sign_reg  <= multiplicand[MA-1] ^ multiplier[MB-1];
                  mag_a_reg <= mag_a_in;
                  mag_b_reg <= mag_b_in;
                  acc_reg   <= '0;
                  count_reg <= '0;
                  ready_reg <= 1'b0;
                  // Zero shortcut: acc is already the answer.
                  state_reg <= zero_in ? EPILOGUE : LOOP;
               end
            end
            LOOP: begin
               // The loop always runs exactly MB iterations, so latency does
               // not depend on the data. It does not stop early when magB
               // becomes zero.
               if (mag_b_reg[0]) begin
                  acc_reg <= acc_reg + (addend << count_reg);
               end
               mag_b_reg <= mag_b_reg >> 1;
               count_reg <= count_reg + CW'(1);
               if (count_reg == LAST_COUNT) begin
                  state_reg <= EPILOGUE;
               end
            end
            EPILOGUE: begin
               product_reg   <= sign_reg ? (PW'(0) - acc_reg) : acc_reg;
               valid_out_reg <= 1'b1;
               state_reg     <= DONE;
            end
            DONE: begin
               ready_reg <= 1'b1;
               state_reg <= IDLE;
            end
            default: begin
               ready_reg <= 1'b1;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign ready     = ready_reg;
   assign valid_out = valid_out_reg;
   assign product   = product_reg;

endmodule
